// File: rtl/frame_rd_if.sv
// frame_rd_if
// Fetches one stored frame from DDR through the MIG user read port and pushes
// each returned 256-bit word into the output buffer FIFO. Single clock domain.
//
// Ports
//   mem_clk, mem_reset_n   UI clock, asynchronous active-low reset
//   start                  one-cycle pulse launching a frame read (ignored unless idle)
//   start_addr, num_bursts frame byte address and length in bursts, sampled with start
//   busy, frame_read       busy from accepted start to the frame_read pulse
//   unexp_data             sticky flag: read data arrived with nothing outstanding
//   mem_rd_req/addr/ack    read command handshake towards the MIG arbiter
//   mem_rd_valid/data      returned read data, one word per accepted command
//   ob_count               output FIFO write-side occupancy
//   ob_wr_en, ob_wr_data   output FIFO write port
//
// state | meaning
// IDLE  | waiting for start; also emits frame_read for a zero-length frame
// CHECK | decide: all issued -> DRAIN, else request when credit allows
// ISSUE | mem_rd_req held high until the arbiter acks
// DRAIN | wait for outstanding data and the final FIFO write
module frame_rd_if #(
    parameter int ADDRESS_INCREMENT = 8,
    parameter int MAX_OUTSTANDING   = 4,
    parameter int FIFO_DEPTH        = 256
) (
    input  logic         mem_clk,
    input  logic         mem_reset_n,
    input  logic         start,
    input  logic [29:0]  start_addr,
    input  logic [19:0]  num_bursts,
    output logic         busy,
    output logic         frame_read,
    output logic         unexp_data,
    output logic         mem_rd_req,
    output logic [28:0]  mem_rd_addr,
    input  logic         mem_rd_ack,
    input  logic         mem_rd_valid,
    input  logic [255:0] mem_rd_data,
    input  logic [8:0]   ob_count,
    output logic         ob_wr_en,
    output logic [255:0] ob_wr_data
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);
    localparam logic [28:0]   ADDR_INC = 29'(ADDRESS_INCREMENT);
    localparam logic [10:0]   DEPTH    = 11'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DRAIN} state_t;

    state_t        state;
    logic [19:0]   remaining;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] outstanding_nxt;
    logic          rd_take;
    logic          cmd_accept;
    logic          credit_ok;
    logic          addr_lsb_unused;

    // The memory word address drops the byte-address LSB.
    assign addr_lsb_unused = start_addr[0];

    // Data is only accepted against an outstanding command; anything else is dropped.
    assign rd_take    = mem_rd_valid && (outstanding != '0);
    assign cmd_accept = (state == ISSUE) && mem_rd_ack;

    // Reserve FIFO space for every word already in flight so writes never need gating.
    assign credit_ok = (outstanding < MAX_OUT) &&
                       ((11'(ob_count) + 11'(outstanding) + 11'd1) <= DEPTH);

    always_comb begin
        outstanding_nxt = outstanding;
        case ({cmd_accept, rd_take})
            2'b10:   outstanding_nxt = outstanding + 1'b1;
            2'b01:   outstanding_nxt = outstanding - 1'b1;
            default: outstanding_nxt = outstanding;
        endcase
    end

    always_ff @(posedge mem_clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_read  <= 1'b0;
            unexp_data  <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            remaining   <= '0;
            outstanding <= '0;
            ob_wr_en    <= 1'b0;
            ob_wr_data  <= '0;
        end else begin
            frame_read  <= 1'b0;
            ob_wr_en    <= rd_take;
            outstanding <= outstanding_nxt;
            if (rd_take) begin
                ob_wr_data <= mem_rd_data;
            end

            case (state)
                IDLE: begin
                    // busy while idle only happens right after a zero-length start
                    if (busy) begin
                        frame_read <= 1'b1;
                        busy       <= 1'b0;
                    end else if (start) begin
                        mem_rd_addr <= start_addr[29:1];
                        remaining   <= num_bursts;
                        busy        <= 1'b1;
                        unexp_data  <= 1'b0;
                        if (num_bursts != '0) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (remaining == '0) begin
                        state <= DRAIN;
                    end else if (credit_ok) begin
                        mem_rd_req <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_rd_ack) begin
                        mem_rd_req  <= 1'b0;
                        mem_rd_addr <= mem_rd_addr + ADDR_INC;
                        remaining   <= remaining - 20'd1;
                        state       <= CHECK;
                    end
                end
                DRAIN: begin
                    // the last word is written while ob_wr_en is high; finish after it
                    if ((outstanding == '0) && !ob_wr_en) begin
                        frame_read <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // placed last so stray data in the same cycle as a start still flags
            if (mem_rd_valid && (outstanding == '0)) begin
                unexp_data <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_rd_if.sv
// tb_frame_rd_if
// Drives frame reads against a behavioural MIG responder (random ack delay and
// read latency, in-order data) and compares command addresses, FIFO writes and
// handshake flags with values computed from the frame parameters.
module tb_frame_rd_if;

    logic         mem_clk = 1'b0;
    logic         mem_reset_n = 1'b0;
    logic         start = 1'b0;
    logic [29:0]  start_addr = '0;
    logic [19:0]  num_bursts = '0;
    logic         busy;
    logic         frame_read;
    logic         unexp_data;
    logic         mem_rd_req;
    logic [28:0]  mem_rd_addr;
    logic         mem_rd_ack = 1'b0;
    logic         mem_rd_valid = 1'b0;
    logic [255:0] mem_rd_data = '0;
    logic [8:0]   ob_count = '0;
    logic         ob_wr_en;
    logic [255:0] ob_wr_data;

    frame_rd_if dut (
        .mem_clk      (mem_clk),
        .mem_reset_n  (mem_reset_n),
        .start        (start),
        .start_addr   (start_addr),
        .num_bursts   (num_bursts),
        .busy         (busy),
        .frame_read   (frame_read),
        .unexp_data   (unexp_data),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_ack   (mem_rd_ack),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .ob_count     (ob_count),
        .ob_wr_en     (ob_wr_en),
        .ob_wr_data   (ob_wr_data)
    );

    always #5 mem_clk = ~mem_clk;

    int checks = 0;
    int errors = 0;

    // responder configuration
    int  ack_delay = 0;
    int  lat_min = 1;
    int  lat_max = 3;
    bit  hold_data = 1'b0;
    bit  inject_req = 1'b0;
    bit  mig_clear = 1'b0;

    logic [255:0] pend_q[$];
    int           pend_due[$];
    logic [255:0] exp_wr_q[$];
    logic [28:0]  got_addr_q[$];
    logic [255:0] got_wr_q[$];
    int n_ack = 0;
    int n_frame_read = 0;
    int n_coinc = 0;
    int n_req_cycles = 0;
    int model_out = 0;
    int max_out = 0;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [28:0] exp_addr(input logic [29:0] a, input int i);
        longint w;
        w = (longint'(a) / 2 + longint'(i) * 8) % (longint'(1) << 29);
        return w[28:0];
    endfunction

    // MIG model: acks requests after ack_delay cycles, returns data in order
    initial begin
        int  ack_wait;
        logic [255:0] d;
        ack_wait = 0;
        forever begin
            @(negedge mem_clk);
            #1;
            mem_rd_ack   = 1'b0;
            mem_rd_valid = 1'b0;
            for (int k = 0; k < pend_due.size(); k++) pend_due[k] = pend_due[k] - 1;
            if (mig_clear) begin
                pend_q.delete();
                pend_due.delete();
                ack_wait  = 0;
                mig_clear = 1'b0;
            end
            if (inject_req) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = rand256();
                inject_req   = 1'b0;
            end else if (!hold_data && pend_q.size() > 0 && pend_due[0] <= 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = pend_q.pop_front();
                void'(pend_due.pop_front());
                exp_wr_q.push_back(mem_rd_data);
            end
            if (mem_rd_req && mem_reset_n) begin
                if (ack_wait >= ack_delay) begin
                    mem_rd_ack = 1'b1;
                    ack_wait   = 0;
                    d = rand256();
                    pend_q.push_back(d);
                    pend_due.push_back($urandom_range(lat_max, lat_min));
                end else begin
                    ack_wait++;
                end
            end
        end
    end

    // observation just before each rising edge, where inputs and outputs are settled
    initial begin
        bit acc, ret;
        forever begin
            @(negedge mem_clk);
            #4;
            if (!mem_reset_n) begin
                model_out = 0;
            end else begin
                acc = mem_rd_req && mem_rd_ack;
                ret = mem_rd_valid && (model_out > 0);
                if (acc) begin
                    got_addr_q.push_back(mem_rd_addr);
                    n_ack++;
                    if (mem_rd_valid) n_coinc++;
                end
                model_out = model_out + (acc ? 1 : 0) - (ret ? 1 : 0);
                if (model_out > max_out) max_out = model_out;
                if (ob_wr_en) got_wr_q.push_back(ob_wr_data);
                if (frame_read) n_frame_read++;
                if (mem_rd_req) n_req_cycles++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_sb();
        exp_wr_q.delete();
        got_addr_q.delete();
        got_wr_q.delete();
        n_ack = 0;
        n_frame_read = 0;
        n_coinc = 0;
        n_req_cycles = 0;
        max_out = 0;
    endtask

    task automatic launch(input logic [29:0] a, input logic [19:0] n);
        @(negedge mem_clk);
        start_addr = a;
        num_bursts = n;
        start = 1'b1;
        @(negedge mem_clk);
        start = 1'b0;
    endtask

    task automatic wait_frame(input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge mem_clk);
            if (n_frame_read != 0) begin
                done = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge mem_clk);
    endtask

    task automatic test_reset();
        mem_reset_n = 1'b0;
        repeat (3) @(negedge mem_clk);
        checks++;
        if ({busy, frame_read, unexp_data, mem_rd_req, ob_wr_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {busy, frame_read, unexp_data, mem_rd_req, ob_wr_en});
        end
        checks++;
        if (mem_rd_addr !== 29'h0) begin
            errors++;
            $display("FAIL reset_addr got %h want 0", mem_rd_addr);
        end
        checks++;
        if (ob_wr_data !== 256'h0) begin
            errors++;
            $display("FAIL reset_wr_data got %h want 0", ob_wr_data);
        end
        mem_reset_n = 1'b1;
        repeat (2) @(negedge mem_clk);
    endtask

    task automatic test_basic();
        bit done;
        logic [28:0] want[4];
        want[0] = 29'h080; want[1] = 29'h088; want[2] = 29'h090; want[3] = 29'h098;
        clear_sb();
        ack_delay = 0; lat_min = 1; lat_max = 3; ob_count = '0;
        launch(30'h100, 20'd4);
        wait_frame(300, done);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done); end
        checks++;
        if (got_addr_q.size() != 4) begin
            errors++;
            $display("FAIL basic_acks got %0d want 4", got_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_addr_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL basic_addr[%0d] got %h want %h", i, got_addr_q[i], want[i]);
                end
            end
        end
        checks++;
        if (got_wr_q.size() != 4 || got_wr_q != exp_wr_q) begin
            errors++;
            $display("FAIL basic_writes got %0d words want 4 matching returned data", got_wr_q.size());
        end
        checks++;
        if (n_frame_read != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end frame_read pulses %0d busy %b want 1 and 0", n_frame_read, busy);
        end
    endtask

    task automatic test_outstanding();
        bit done;
        logic [29:0] a;
        clear_sb();
        a = {$urandom_range(32'h1FFF_FFFF, 0)} << 1;
        ack_delay = 0; lat_min = 1; lat_max = 2; hold_data = 1'b1; ob_count = '0;
        launch(a, 20'd10);
        repeat (30) @(negedge mem_clk);
        checks++;
        if (n_ack != 4 || mem_rd_req !== 1'b0) begin
            errors++;
            $display("FAIL outstanding_limit acks %0d req %b want 4 and 0", n_ack, mem_rd_req);
        end
        hold_data = 1'b0;
        wait_frame(500, done);
        checks++;
        if (done !== 1'b1 || n_ack != 10) begin
            errors++;
            $display("FAIL outstanding_done done %b acks %0d want 1 and 10", done, n_ack);
        end
        checks++;
        if (max_out > 4) begin
            errors++;
            $display("FAIL outstanding_max got %0d want <= 4", max_out);
        end
        checks++;
        if (got_wr_q.size() != 10 || got_wr_q != exp_wr_q) begin
            errors++;
            $display("FAIL outstanding_writes got %0d words want 10 matching", got_wr_q.size());
        end
        for (int i = 0; i < got_addr_q.size() && i < 10; i++) begin
            checks++;
            if (got_addr_q[i] !== exp_addr(a, i)) begin
                errors++;
                $display("FAIL outstanding_addr[%0d] got %h want %h", i, got_addr_q[i], exp_addr(a, i));
            end
        end
    endtask

    task automatic test_credit();
        bit done;
        clear_sb();
        ack_delay = 1; lat_min = 1; lat_max = 3; hold_data = 1'b1; ob_count = 9'd253;
        launch(30'h0000_2000, 20'd5);
        repeat (30) @(negedge mem_clk);
        checks++;
        if (n_ack != 3 || mem_rd_req !== 1'b0) begin
            errors++;
            $display("FAIL credit_limit acks %0d req %b want 3 and 0", n_ack, mem_rd_req);
        end
        ob_count = 9'd0;
        hold_data = 1'b0;
        wait_frame(500, done);
        checks++;
        if (done !== 1'b1 || n_ack != 5 || got_wr_q.size() != 5 || got_wr_q != exp_wr_q) begin
            errors++;
            $display("FAIL credit_resume done %b acks %0d writes %0d want 1, 5, 5", done, n_ack, got_wr_q.size());
        end
    endtask

    task automatic test_wrap();
        bit done;
        logic [28:0] want[3];
        want[0] = 29'h1FFF_FFF8; want[1] = 29'h0; want[2] = 29'h8;
        clear_sb();
        ack_delay = 0; lat_min = 1; lat_max = 4; ob_count = '0;
        launch(30'h3FFF_FFF0, 20'd3);
        wait_frame(300, done);
        checks++;
        if (done !== 1'b1 || got_addr_q.size() != 3) begin
            errors++;
            $display("FAIL wrap_done done %b acks %0d want 1 and 3", done, got_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_addr_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL wrap_addr[%0d] got %h want %h", i, got_addr_q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_collision();
        bit done;
        int n_wr_before;
        clear_sb();
        ack_delay = 0; lat_min = 2; lat_max = 2; ob_count = 9'd10;
        launch(30'h0001_0000, 20'd6);
        wait_frame(300, done);
        checks++;
        if (n_coinc == 0) begin
            errors++;
            $display("FAIL collision_seen ack-with-valid cycles %0d want > 0", n_coinc);
        end
        checks++;
        if (done !== 1'b1 || got_wr_q.size() != 6 || got_wr_q != exp_wr_q || max_out > 4) begin
            errors++;
            $display("FAIL collision_frame done %b writes %0d max_out %0d want 1, 6, <=4", done, got_wr_q.size(), max_out);
        end
        checks++;
        if (unexp_data !== 1'b0) begin
            errors++;
            $display("FAIL collision_no_unexp got %b want 0", unexp_data);
        end
        n_wr_before = got_wr_q.size();
        inject_req = 1'b1;
        repeat (5) @(negedge mem_clk);
        checks++;
        if (unexp_data !== 1'b1) begin
            errors++;
            $display("FAIL unexp_set got %b want 1", unexp_data);
        end
        checks++;
        if (got_wr_q.size() != n_wr_before || busy !== 1'b0) begin
            errors++;
            $display("FAIL unexp_dropped writes %0d busy %b want %0d and 0", got_wr_q.size(), busy, n_wr_before);
        end
        clear_sb();
        launch(30'h0, 20'd0);
        wait_frame(20, done);
        checks++;
        if (done !== 1'b1 || unexp_data !== 1'b0) begin
            errors++;
            $display("FAIL unexp_clear_on_start done %b unexp %b want 1 and 0", done, unexp_data);
        end
    endtask

    task automatic test_random_frames();
        bit done;
        logic [29:0] a;
        int n;
        for (int f = 0; f < 6; f++) begin
            clear_sb();
            a = $urandom_range(32'h3FFF_FFFF, 0);
            n = $urandom_range(12, 1);
            ack_delay = $urandom_range(3, 0);
            lat_min = $urandom_range(3, 1);
            lat_max = lat_min + $urandom_range(4, 0);
            ob_count = 9'($urandom_range(255, 0));
            launch(a, 20'(n));
            repeat (2) @(negedge mem_clk);
            // a second start while busy must be ignored
            launch(a ^ 30'h0AAA_AAAA, 20'(n + 3));
            wait_frame(2000, done);
            checks++;
            if (done !== 1'b1 || n_frame_read != 1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_end done %b pulses %0d busy %b want 1, 1, 0", f, done, n_frame_read, busy);
            end
            checks++;
            if (got_addr_q.size() != n) begin
                errors++;
                $display("FAIL rand%0d_acks got %0d want %0d", f, got_addr_q.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (got_addr_q[i] !== exp_addr(a, i)) begin
                        errors++;
                        $display("FAIL rand%0d_addr[%0d] got %h want %h", f, i, got_addr_q[i], exp_addr(a, i));
                    end
                end
            end
            checks++;
            if (got_wr_q.size() != n || got_wr_q != exp_wr_q) begin
                errors++;
                $display("FAIL rand%0d_writes got %0d words want %0d matching", f, got_wr_q.size(), n);
            end
            checks++;
            if (max_out > 4 || unexp_data !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_flow max_out %0d unexp %b want <=4 and 0", f, max_out, unexp_data);
            end
        end
        ob_count = '0;
    endtask

    task automatic test_reset_midframe();
        bit done;
        bit got2;
        clear_sb();
        ack_delay = 0; lat_min = 1; lat_max = 2; hold_data = 1'b1; ob_count = '0;
        launch(30'h0000_4000, 20'd6);
        got2 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge mem_clk);
            if (n_ack >= 2) begin
                got2 = 1'b1;
                break;
            end
        end
        checks++;
        if (got2 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_two_acks got %0d acks want 2", n_ack);
        end
        mem_reset_n = 1'b0;
        mig_clear = 1'b1;
        repeat (2) @(negedge mem_clk);
        checks++;
        if ({busy, frame_read, unexp_data, mem_rd_req, ob_wr_en} !== 5'b0 || mem_rd_addr !== 29'h0 || ob_wr_data !== 256'h0) begin
            errors++;
            $display("FAIL midreset_values flags %b addr %h want 00000 and 0", {busy, frame_read, unexp_data, mem_rd_req, ob_wr_en}, mem_rd_addr);
        end
        hold_data = 1'b0;
        mem_reset_n = 1'b1;
        repeat (2) @(negedge mem_clk);
        clear_sb();
        launch(30'h0000_8000, 20'd0);
        wait_frame(20, done);
        checks++;
        if (done !== 1'b1 || n_frame_read != 1) begin
            errors++;
            $display("FAIL zero_len_pulse done %b pulses %0d want 1 and 1", done, n_frame_read);
        end
        checks++;
        if (n_req_cycles != 0 || busy !== 1'b0 || unexp_data !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_quiet req cycles %0d busy %b unexp %b want 0, 0, 0", n_req_cycles, busy, unexp_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_outstanding();
        test_credit();
        test_wrap();
        test_collision();
        test_random_frames();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
